udp_srio_packer: RTL and testbench
==================================

UDP_SRIO_PACKER -- requirements
Module: udp_srio_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning input word width in bits (multiple of 8).
REQ-002 SHALL have parameter RATIO, default 2, meaning input words per output beat (>=2); OUT_WIDTH = IN_WIDTH*RATIO.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning packet byte-counter width.
REQ-004 SHALL use one clock and a synchronous active-low reset.
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
REQ-005 SHALL provide these ports:
- s_data_in  in  IN_WIDTH  input word
- s_valid_in  in  1  input word valid
- s_first_in  in  1  first word of packet
- s_keep_in  in  IN_WIDTH/8  byte enables, MSB-aligned contiguous
- s_last_in  in  1  last word of packet
- s_ready_out  out  1  input accepted when s_valid_in & s_ready_out
- m_ready_in  in  1  downstream ready
- m_data_out  out  OUT_WIDTH  packed beat
- m_valid_out  out  1  beat valid
- m_first_out  out  1  first beat of packet
- m_keep_out  out  OUT_WIDTH/8  beat byte enables
- m_last_out  out  1  last beat of packet
- m_byte_cnt_out  out  LEN_WIDTH  packet byte total, valid with m_last_out
- nwr_req_out  out  1  one-cycle NWRITE request pulse
- err_out  out  1  one-cycle protocol-error pulse

Function
REQ-006 SHALL implement FSM IDLE/PACK; reset -> IDLE.
REQ-007 IDLE: accepted word with s_first_in -> PACK (or stays IDLE if s_last_in also set); accepted word without s_first_in -> dropped, err_out pulse, stay IDLE.
REQ-008 PACK: accepted word with s_last_in -> IDLE; accepted word with s_first_in -> err_out pulse, partial beat discarded, word starts new packet at lane 0.
REQ-009 Lane counter 0..RATIO-1; lane 0 occupies MSBs of beat (big-endian, first word in MSB lane); counter increments per accepted word, wraps RATIO-1 -> 0, clears on last or restart.
REQ-010 Beat completes when word accepted in lane RATIO-1 or with s_last_in; unfilled lanes SHALL carry data 0 and keep 0.
REQ-011 Completed beat SHALL appear on m_* registers the cycle after the completing word is accepted (latency 1).
REQ-012 s_ready_out = ~m_valid_out | m_ready_in; no word lost or duplicated under any m_ready_in pattern.
REQ-013 m_* outputs SHALL hold stable while m_valid_out & ~m_ready_in.
REQ-014 m_first_out set only on first beat of packet; m_last_out only on final beat; single-beat packet sets both.
REQ-015 Byte counter SHALL load popcount(s_keep_in) on a first word and add popcount on each subsequent accepted word; saturates at 2^LEN_WIDTH-1.
REQ-016 m_byte_cnt_out SHALL equal final count while m_valid_out & m_last_out, else 0.
REQ-017 nwr_req_out SHALL pulse exactly one cycle when beat with m_first_out handshakes (m_valid_out & m_ready_in).
REQ-018 s_keep_in ignored (treated as all-ones) on non-last words.

Reset
REQ-019 reset_n=0 at clock edge SHALL force: FSM IDLE, lane 0, counter 0, m_valid_out/m_first_out/m_last_out/nwr_req_out/err_out 0, m_data_out 0, m_keep_out 0, m_byte_cnt_out 0.
REQ-020 Reset mid-packet SHALL discard partial beat and pending output; s_ready_out =1 after reset.

Verification (IN_WIDTH=32, RATIO=2)
REQ-021 4 words A,B,C,D (first on A, last on D, keep F), m_ready_in=1 -> beats {A,B} keep FF first, {C,D} keep FF last, byte_cnt 16, one nwr_req pulse.
REQ-022 3 words, last keep 0xC -> second beat data {C,0} keep C0 last, byte_cnt 10.
REQ-023 Single word first+last keep 0xE -> one beat first=last=1, keep E0, byte_cnt 3.
REQ-024 8-word packet with m_ready_in toggling 1/0 each cycle -> 4 beats, order preserved, outputs stable while stalled, s_ready_out low when m_valid_out & ~m_ready_in.
REQ-025 New first after 3 words without last -> err_out one pulse, partial {C,-} never emitted, new packet packs from lane 0; valid without first in IDLE -> dropped, err_out pulse.
REQ-026 reset_n low one cycle after first word of 4-word packet -> all outputs 0; next clean packet output correct.

Source files
------------

// File: rtl/udp_srio_packer.sv
// udp_srio_packer: packs RATIO narrow input words into one wide big-endian beat,
// tracks the packet byte total and raises an NWRITE request on each packet's first beat.
module udp_srio_packer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned RATIO     = 2,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [IN_WIDTH-1:0]              s_data_in,
    input  logic                             s_valid_in,
    input  logic                             s_first_in,
    input  logic [IN_WIDTH/8-1:0]            s_keep_in,
    input  logic                             s_last_in,
    output logic                             s_ready_out,
    input  logic                             m_ready_in,
    output logic [IN_WIDTH*RATIO-1:0]        m_data_out,
    output logic                             m_valid_out,
    output logic                             m_first_out,
    output logic [IN_WIDTH*RATIO/8-1:0]      m_keep_out,
    output logic                             m_last_out,
    output logic [LEN_WIDTH-1:0]             m_byte_cnt_out,
    output logic                             nwr_req_out,
    output logic                             err_out
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned IN_KW     = IN_WIDTH / 8;
    localparam int unsigned OUT_KW    = OUT_WIDTH / 8;
    localparam int unsigned LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned POP_W     = $clog2(IN_KW + 1);
    localparam int unsigned SUM_W     = LEN_WIDTH + 1;

    typedef enum logic {IDLE, PACK} state_e;

    state_e                 state_q;
    logic [LANE_W-1:0]      lane_q;
    logic [OUT_WIDTH-1:0]   buf_q;
    logic [OUT_KW-1:0]      kbuf_q;
    logic                   beat_first_q;
    logic [LEN_WIDTH-1:0]   cnt_q;

    logic [OUT_WIDTH-1:0]   m_data_q;
    logic [OUT_KW-1:0]      m_keep_q;
    logic                   m_valid_q;
    logic                   m_first_q;
    logic                   m_last_q;
    logic [LEN_WIDTH-1:0]   m_cnt_q;
    logic                   nwr_q;
    logic                   err_q;

    logic                   accept;
    logic                   start;
    logic                   word_ok;
    logic                   proto_err;
    logic                   complete;
    logic                   beat_first_d;
    logic [LANE_W-1:0]      eff_lane;
    logic [IN_KW-1:0]       word_keep;
    logic [POP_W-1:0]       pop;
    logic [SUM_W-1:0]       sum;
    logic [LEN_WIDTH-1:0]   cnt_d;
    logic [OUT_WIDTH-1:0]   buf_d;
    logic [OUT_KW-1:0]      kbuf_d;

    assign s_ready_out    = ~m_valid_q | m_ready_in;
    assign m_data_out     = m_data_q;
    assign m_keep_out     = m_keep_q;
    assign m_valid_out    = m_valid_q;
    assign m_first_out    = m_first_q;
    assign m_last_out     = m_last_q;
    assign m_byte_cnt_out = m_cnt_q;
    assign nwr_req_out    = nwr_q;
    assign err_out        = err_q;

    // Word acceptance, lane placement, byte accounting and beat completion
    always_comb begin
        accept       = s_valid_in & s_ready_out;
        start        = accept & s_first_in;
        word_ok      = start | (accept & (state_q == PACK));
        proto_err    = accept & (((state_q == IDLE) & ~s_first_in) |
                                 ((state_q == PACK) &  s_first_in));
        eff_lane     = start ? '0 : lane_q;
        beat_first_d = start | beat_first_q;
        word_keep    = s_last_in ? s_keep_in : '1;
        pop          = '0;
        for (int i = 0; i < int'(IN_KW); i++) begin
            pop = pop + POP_W'(word_keep[i]);
        end
        sum   = SUM_W'(start ? '0 : cnt_q) + SUM_W'(pop);
        cnt_d = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
        buf_d  = start ? '0 : buf_q;
        kbuf_d = start ? '0 : kbuf_q;
        for (int l = 0; l < int'(RATIO); l++) begin
            if (LANE_W'(l) == eff_lane) begin
                buf_d[OUT_WIDTH-1-l*IN_WIDTH -: IN_WIDTH] = s_data_in;
                kbuf_d[OUT_KW-1-l*IN_KW -: IN_KW]         = word_keep;
            end
        end
        complete = word_ok & (s_last_in | (eff_lane == LANE_W'(RATIO - 1)));
    end

    // FSM, packing registers and registered output beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            buf_q        <= '0;
            kbuf_q       <= '0;
            beat_first_q <= 1'b0;
            cnt_q        <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_cnt_q      <= '0;
            nwr_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= proto_err;
            nwr_q <= m_valid_q & m_ready_in & m_first_q;
            if (word_ok) begin
                state_q      <= s_last_in ? IDLE : PACK;
                lane_q       <= complete ? '0 : LANE_W'(eff_lane + LANE_W'(1));
                buf_q        <= complete ? '0 : buf_d;
                kbuf_q       <= complete ? '0 : kbuf_d;
                beat_first_q <= complete ? 1'b0 : beat_first_d;
                cnt_q        <= s_last_in ? '0 : cnt_d;
            end
            if (complete) begin
                m_data_q  <= buf_d;
                m_keep_q  <= kbuf_d;
                m_valid_q <= 1'b1;
                m_first_q <= beat_first_d;
                m_last_q  <= s_last_in;
                m_cnt_q   <= s_last_in ? cnt_d : '0;
            end else if (m_valid_q & m_ready_in) begin
                m_data_q  <= '0;
                m_keep_q  <= '0;
                m_valid_q <= 1'b0;
                m_first_q <= 1'b0;
                m_last_q  <= 1'b0;
                m_cnt_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udp_srio_packer.sv
// Directed bench for udp_srio_packer (IN_WIDTH=32, RATIO=2, LEN_WIDTH=16).
module tb_udp_srio_packer;

    logic        clk;
    logic        reset_n;
    logic [31:0] s_data_in;
    logic        s_valid_in;
    logic        s_first_in;
    logic [3:0]  s_keep_in;
    logic        s_last_in;
    logic        s_ready_out;
    logic        m_ready_in;
    logic [63:0] m_data_out;
    logic        m_valid_out;
    logic        m_first_out;
    logic [7:0]  m_keep_out;
    logic        m_last_out;
    logic [15:0] m_byte_cnt_out;
    logic        nwr_req_out;
    logic        err_out;

    udp_srio_packer #(.IN_WIDTH(32), .RATIO(2), .LEN_WIDTH(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_data_in      (s_data_in),
        .s_valid_in     (s_valid_in),
        .s_first_in     (s_first_in),
        .s_keep_in      (s_keep_in),
        .s_last_in      (s_last_in),
        .s_ready_out    (s_ready_out),
        .m_ready_in     (m_ready_in),
        .m_data_out     (m_data_out),
        .m_valid_out    (m_valid_out),
        .m_first_out    (m_first_out),
        .m_keep_out     (m_keep_out),
        .m_last_out     (m_last_out),
        .m_byte_cnt_out (m_byte_cnt_out),
        .nwr_req_out    (nwr_req_out),
        .err_out        (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nwr_cnt = 0;
    int err_cnt = 0;
    logic toggle_en = 1'b0;

    logic [63:0] got_data[$];
    logic [25:0] got_flags[$];
    logic [63:0] exp_data[$];
    logic [25:0] exp_flags[$];

    logic        stall_prev = 1'b0;
    logic [63:0] hold_data;
    logic [25:0] hold_flags;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture handshaken beats, count pulses, and check stall behaviour
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("hold_data", m_data_out, hold_data);
            chk("hold_flags", 64'({m_keep_out, m_first_out, m_last_out, m_byte_cnt_out}), 64'(hold_flags));
        end
        if (m_valid_out && !m_ready_in) chk("ready_low_on_stall", 64'(s_ready_out), 64'd0);
        stall_prev = m_valid_out & ~m_ready_in;
        hold_data  = m_data_out;
        hold_flags = {m_keep_out, m_first_out, m_last_out, m_byte_cnt_out};
        if (m_valid_out && m_ready_in) begin
            got_data.push_back(m_data_out);
            got_flags.push_back({m_keep_out, m_first_out, m_last_out, m_byte_cnt_out});
        end
        if (nwr_req_out) nwr_cnt++;
        if (err_out) err_cnt++;
    end

    // Ready toggling for the backpressure test
    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) m_ready_in = ~m_ready_in;
    end

    task automatic send(input logic [31:0] d, input logic f, input logic l, input logic [3:0] k);
        int n;
        n = 0;
        s_data_in  = d;
        s_first_in = f;
        s_last_in  = l;
        s_keep_in  = k;
        s_valid_in = 1'b1;
        @(negedge clk);
        while (!s_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_out) chk("send_timeout", 64'(s_ready_out), 64'd1);
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        s_first_in = 1'b0;
        s_last_in  = 1'b0;
    endtask

    task automatic exp_beat(input logic [63:0] d, input logic [7:0] k, input logic f,
                            input logic l, input logic [15:0] c);
        exp_data.push_back(d);
        exp_flags.push_back({k, f, l, c});
    endtask

    task automatic drain_and_compare(input string tag, input int exp_nwr, input int exp_err);
        int n;
        m_ready_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_beats"}, 64'(got_data.size()), 64'(exp_data.size()));
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            chk($sformatf("%s_flags%0d", tag, i), 64'(got_flags[i]), 64'(exp_flags[i]));
        end
        chk({tag, "_nwr"}, 64'(nwr_cnt), 64'(exp_nwr));
        chk({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
        got_data.delete();
        got_flags.delete();
        exp_data.delete();
        exp_flags.delete();
        nwr_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 64'(m_valid_out), 64'd0);
        chk({tag, "_data"}, m_data_out, 64'd0);
        chk({tag, "_flags"}, 64'({m_keep_out, m_first_out, m_last_out, m_byte_cnt_out}), 64'd0);
        chk({tag, "_pulses"}, 64'({nwr_req_out, err_out}), 64'd0);
        chk({tag, "_ready"}, 64'(s_ready_out), 64'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        s_data_in  = '0;
        s_valid_in = 1'b0;
        s_first_in = 1'b0;
        s_keep_in  = '0;
        s_last_in  = 1'b0;
        m_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Four full words, two beats
        send(32'h11111111, 1, 0, 4'hF);
        send(32'h22222222, 0, 0, 4'hF);
        send(32'h33333333, 0, 0, 4'hF);
        send(32'h44444444, 0, 1, 4'hF);
        exp_beat(64'h11111111_22222222, 8'hFF, 1, 0, 16'd0);
        exp_beat(64'h33333333_44444444, 8'hFF, 0, 1, 16'd16);
        drain_and_compare("four", 1, 0);

        // Three words, partial last word; keep on non-last words is ignored
        send(32'hAAAA0001, 1, 0, 4'h0);
        send(32'hAAAA0002, 0, 0, 4'h1);
        send(32'hCCCC0003, 0, 1, 4'hC);
        exp_beat(64'hAAAA0001_AAAA0002, 8'hFF, 1, 0, 16'd0);
        exp_beat(64'hCCCC0003_00000000, 8'hC0, 0, 1, 16'd10);
        drain_and_compare("three", 1, 0);

        // Single-word packet
        send(32'hDEADBEEF, 1, 1, 4'hE);
        exp_beat(64'hDEADBEEF_00000000, 8'hE0, 1, 1, 16'd3);
        drain_and_compare("single", 1, 0);

        // Eight words under toggling downstream ready
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'hA0000000 | 32'(i), (i == 0), (i == 7), 4'hF);
        end
        repeat (8) @(posedge clk);
        #1;
        toggle_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_beat({32'hA0000000 | 32'(2*i), 32'hA0000000 | 32'(2*i+1)}, 8'hFF,
                     (i == 0), (i == 3), (i == 3) ? 16'd32 : 16'd0);
        end
        drain_and_compare("stall", 1, 0);

        // Restart mid-packet, then a stray word in IDLE
        send(32'h0000000A, 1, 0, 4'hF);
        send(32'h0000000B, 0, 0, 4'hF);
        send(32'h0000000C, 0, 0, 4'hF);
        send(32'h0000000E, 1, 0, 4'hF);
        send(32'h0000000F, 0, 1, 4'hF);
        exp_beat(64'h0000000A_0000000B, 8'hFF, 1, 0, 16'd0);
        exp_beat(64'h0000000E_0000000F, 8'hFF, 1, 1, 16'd8);
        drain_and_compare("restart", 2, 1);
        send(32'h12345678, 0, 0, 4'hF);
        drain_and_compare("stray", 0, 1);

        // Reset after the first word of a packet, then a clean packet
        send(32'h55555555, 1, 0, 4'hF);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        got_data.delete();
        got_flags.delete();
        nwr_cnt = 0;
        err_cnt = 0;
        send(32'h66666666, 1, 0, 4'hF);
        send(32'h77777777, 0, 0, 4'hF);
        send(32'h88888888, 0, 0, 4'hF);
        send(32'h99999999, 0, 1, 4'h8);
        exp_beat(64'h66666666_77777777, 8'hFF, 1, 0, 16'd0);
        exp_beat(64'h88888888_99999999, 8'hF8, 0, 1, 16'd13);
        drain_and_compare("postreset", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
